// File: rtl/a2d_sched.sv
// Round-robin A2D conversion scheduler: runs two SPI transactions per channel
// (select, then read) and keeps the latest 12-bit result of each of four channels.
module a2d_sched #(
  parameter int GAP_CYC = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        nxt,
  input  logic        done,
  input  logic [15:0] resp,
  output logic        wrt,
  output logic [15:0] cmd,
  output logic [11:0] lft_ld,
  output logic [11:0] rght_ld,
  output logic [11:0] steer_pot,
  output logic [11:0] batt,
  output logic        busy,
  output logic        cnv_cmplt,
  output logic [1:0]  rr_idx
);

  typedef enum logic [1:0] {IDLE, WAIT1, GAP, WAIT2} state_t;

  localparam logic [3:0] GAP_LAST = (GAP_CYC == 0) ? 4'd0 : 4'(GAP_CYC - 1);

  state_t      state_reg, state_next;
  logic [3:0]  gap_cnt_reg, gap_cnt_next;
  logic [1:0]  rr_idx_reg, rr_idx_next;
  logic        wrt_reg, wrt_next;
  logic [15:0] cmd_reg, cmd_next;
  logic        busy_reg, busy_next;
  logic        cnv_cmplt_reg, cnv_cmplt_next;
  logic [3:0]  result_we;
  logic [11:0] result [4];
  logic [2:0]  chnl;
  logic        done_ok;
  logic        unused_resp_hi;

  // Only the low 12 bits carry conversion data.
  assign unused_resp_hi = ^resp[15:12];

  // The SPI master cannot finish in the same cycle it is started.
  assign done_ok = done & ~wrt_reg;

  always_comb begin
    chnl = 3'd0;
    case (rr_idx_reg)
      2'd0: chnl = 3'd0;
      2'd1: chnl = 3'd4;
      2'd2: chnl = 3'd5;
      2'd3: chnl = 3'd6;
      default: chnl = 3'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      gap_cnt_reg   <= 4'd0;
      rr_idx_reg    <= 2'd0;
      wrt_reg       <= 1'b0;
      cmd_reg       <= 16'h0000;
      busy_reg      <= 1'b0;
      cnv_cmplt_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      gap_cnt_reg   <= gap_cnt_next;
      rr_idx_reg    <= rr_idx_next;
      wrt_reg       <= wrt_next;
      cmd_reg       <= cmd_next;
      busy_reg      <= busy_next;
      cnv_cmplt_reg <= cnv_cmplt_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    gap_cnt_next   = gap_cnt_reg;
    rr_idx_next    = rr_idx_reg;
    wrt_next       = 1'b0;
    cmd_next       = cmd_reg;
    cnv_cmplt_next = 1'b0;
    result_we      = 4'b0000;
    case (state_reg)
      IDLE: begin
        if (nxt) begin
          state_next = WAIT1;
          wrt_next   = 1'b1;
          cmd_next   = {2'b00, chnl, 11'h000};
        end
      end
      WAIT1: begin
        if (done_ok) begin
          if (GAP_CYC == 0) begin
            state_next = WAIT2;
            wrt_next   = 1'b1;
          end else begin
            state_next   = GAP;
            gap_cnt_next = 4'd0;
          end
        end
      end
      GAP: begin
        if (gap_cnt_reg == GAP_LAST) begin
          state_next = WAIT2;
          wrt_next   = 1'b1;
        end else begin
          gap_cnt_next = gap_cnt_reg + 4'd1;
        end
      end
      WAIT2: begin
        if (done_ok) begin
          state_next            = IDLE;
          result_we[rr_idx_reg] = 1'b1;
          rr_idx_next           = rr_idx_reg + 2'd1;
          cnv_cmplt_next        = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
    busy_next = (state_next != IDLE);
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_result
      logic [11:0] res_reg;
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          res_reg <= 12'h000;
        end else if (result_we[gi]) begin
          res_reg <= resp[11:0];
        end
      end
      assign result[gi] = res_reg;
    end
  endgenerate

  assign wrt       = wrt_reg;
  assign cmd       = cmd_reg;
  assign busy      = busy_reg;
  assign cnv_cmplt = cnv_cmplt_reg;
  assign rr_idx    = rr_idx_reg;
  assign lft_ld    = result[0];
  assign rght_ld   = result[1];
  assign steer_pot = result[2];
  assign batt      = result[3];

endmodule

// File: tb/tb_a2d_sched.sv
// Directed bench for a2d_sched: instance 0 uses GAP_CYC=1, instances 1 and 2
// use GAP_CYC=0 and 5; each has a behavioural SPI/ADC responder.
module tb_a2d_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, nxt, tb_done;
  logic [15:0] tb_resp;
  logic        done_a [3];
  logic [15:0] resp_a [3];
  logic        wrt_a [3];
  logic [15:0] cmd_a [3];
  logic [11:0] lft_a [3], rght_a [3], steer_a [3], batt_a [3];
  logic        busy_a [3], cmplt_a [3];
  logic [1:0]  rr_a [3];

  logic        m_done [3] = '{1'b0, 1'b0, 1'b0};
  logic [15:0] m_resp [3] = '{16'h0, 16'h0, 16'h0};
  int          m_cnt [3]  = '{0, 0, 0};
  logic [2:0]  m_ch [3]   = '{3'd0, 3'd0, 3'd0};
  logic [11:0] adc_val [4];

  int n_checks = 0;
  int n_errors = 0;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_dut
      localparam int G = (gi == 0) ? 1 : ((gi == 1) ? 0 : 5);
      assign done_a[gi] = m_done[gi] | ((gi == 0) && tb_done);
      assign resp_a[gi] = ((gi == 0) && tb_done) ? tb_resp : m_resp[gi];
      a2d_sched #(.GAP_CYC(G)) u_dut (
        .clk(clk), .rst_n(rst_n), .nxt(nxt), .done(done_a[gi]), .resp(resp_a[gi]),
        .wrt(wrt_a[gi]), .cmd(cmd_a[gi]), .lft_ld(lft_a[gi]), .rght_ld(rght_a[gi]),
        .steer_pot(steer_a[gi]), .batt(batt_a[gi]), .busy(busy_a[gi]),
        .cnv_cmplt(cmplt_a[gi]), .rr_idx(rr_a[gi])
      );
    end
  endgenerate

  function automatic logic [11:0] adc_of(input logic [2:0] ch);
    case (ch)
      3'd0: return adc_val[0];
      3'd4: return adc_val[1];
      3'd5: return adc_val[2];
      3'd6: return adc_val[3];
      default: return 12'hEEE;
    endcase
  endfunction

  // SPI responder: done arrives 4 cycles after the wrt cycle; it ignores rst_n
  // so an aborted transaction still produces a stale done. Upper nibble is junk.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      m_done[i] <= 1'b0;
      if (wrt_a[i]) begin
        m_cnt[i] <= 3;
        m_ch[i]  <= cmd_a[i][13:11];
      end else if (m_cnt[i] != 0) begin
        m_cnt[i] <= m_cnt[i] - 1;
        if (m_cnt[i] == 1) begin
          m_done[i] <= 1'b1;
          m_resp[i] <= {4'hA, adc_of(m_ch[i])};
        end
      end
    end
  end

  int          cyc = 0;
  int          wrt0_tot = 0;
  int          cmplt0_tot = 0;
  logic [15:0] cmd_q [$];
  int          wrt_since [3] = '{0, 0, 0};
  int          last_done [3] = '{0, 0, 0};
  int          spacing [3]   = '{0, 0, 0};

  always @(negedge clk) begin
    cyc++;
    if (wrt_a[0]) begin
      wrt0_tot++;
      cmd_q.push_back(cmd_a[0]);
    end
    if (cmplt_a[0]) cmplt0_tot++;
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) wrt_since[i] = 0;
      if (done_a[i]) last_done[i] = cyc;
      if (wrt_a[i]) begin
        wrt_since[i]++;
        if (wrt_since[i] == 2) spacing[i] = cyc - last_done[i];
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic run_conv(output bit ok);
    nxt = 1'b1;
    step();
    nxt = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (cmplt_a[0]) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (wrt_a[0] !== 1'b0) begin n_errors++; $display("FAIL reset_wrt got %b exp 0", wrt_a[0]); end
    n_checks++; if (cmd_a[0] !== 16'h0000) begin n_errors++; $display("FAIL reset_cmd got %h exp 0000", cmd_a[0]); end
    n_checks++; if (busy_a[0] !== 1'b0) begin n_errors++; $display("FAIL reset_busy got %b exp 0", busy_a[0]); end
    n_checks++; if (cmplt_a[0] !== 1'b0) begin n_errors++; $display("FAIL reset_cmplt got %b exp 0", cmplt_a[0]); end
    n_checks++; if (rr_a[0] !== 2'd0) begin n_errors++; $display("FAIL reset_rr got %0d exp 0", rr_a[0]); end
    n_checks++; if ({lft_a[0], rght_a[0], steer_a[0], batt_a[0]} !== 48'h0)
      begin n_errors++; $display("FAIL reset_results got %h %h %h %h exp all 000", lft_a[0], rght_a[0], steer_a[0], batt_a[0]); end
    $display("reset: wrt=%b cmd=%h busy=%b rr=%0d", wrt_a[0], cmd_a[0], busy_a[0], rr_a[0]);
  endtask

  task automatic test_single();
    int w0, c0, q0;
    bit ok;
    adc_val[0] = 12'hC00;
    w0 = wrt0_tot; c0 = cmplt0_tot; q0 = cmd_q.size();
    nxt = 1'b1;
    step();
    nxt = 1'b0;
    n_checks++; if ({wrt_a[0], busy_a[0]} !== 2'b11) begin n_errors++; $display("FAIL single_first_wrt got wrt=%b busy=%b exp 1 1", wrt_a[0], busy_a[0]); end
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (cmplt_a[0]) begin ok = 1'b1; break; end
      step();
    end
    n_checks++; if (!ok) begin n_errors++; $display("FAIL single_cmplt got timeout exp pulse"); end
    n_checks++; if (lft_a[0] !== 12'hC00) begin n_errors++; $display("FAIL single_lft got %h exp C00", lft_a[0]); end
    n_checks++; if (rr_a[0] !== 2'd1) begin n_errors++; $display("FAIL single_rr got %0d exp 1", rr_a[0]); end
    n_checks++; if (busy_a[0] !== 1'b0) begin n_errors++; $display("FAIL single_busy got %b exp 0", busy_a[0]); end
    step();
    n_checks++; if (cmplt_a[0] !== 1'b0) begin n_errors++; $display("FAIL single_cmplt_width got %b exp 0", cmplt_a[0]); end
    step(5);
    n_checks++; if (wrt0_tot - w0 != 2) begin n_errors++; $display("FAIL single_wrt_count got %0d exp 2", wrt0_tot - w0); end
    n_checks++; if (cmd_q[q0] !== 16'h0000 || cmd_q[q0+1] !== 16'h0000)
      begin n_errors++; $display("FAIL single_cmds got %h %h exp 0000 0000", cmd_q[q0], cmd_q[q0+1]); end
    n_checks++; if (cmplt0_tot - c0 != 1) begin n_errors++; $display("FAIL single_cmplt_count got %0d exp 1", cmplt0_tot - c0); end
    $display("single: lft=%h rr=%0d wrts=%0d", lft_a[0], rr_a[0], wrt0_tot - w0);
  endtask

  task automatic test_round_robin();
    logic [15:0] exp_cmd [4];
    int q0;
    bit ok;
    exp_cmd = '{16'h0000, 16'h2000, 16'h2800, 16'h3000};
    do_reset();
    adc_val = '{12'h111, 12'h222, 12'h333, 12'h444};
    for (int k = 0; k < 4; k++) begin
      q0 = cmd_q.size();
      run_conv(ok);
      n_checks++; if (!ok) begin n_errors++; $display("FAIL rr_cmplt_%0d got timeout exp pulse", k); end
      step(2);
      n_checks++; if (cmd_q[q0] !== exp_cmd[k]) begin n_errors++; $display("FAIL rr_cmd_%0d got %h exp %h", k, cmd_q[q0], exp_cmd[k]); end
      $display("round_robin %0d: cmd=%h rr=%0d", k, cmd_q[q0], rr_a[0]);
    end
    n_checks++; if (lft_a[0] !== 12'h111) begin n_errors++; $display("FAIL rr_lft got %h exp 111", lft_a[0]); end
    n_checks++; if (rght_a[0] !== 12'h222) begin n_errors++; $display("FAIL rr_rght got %h exp 222", rght_a[0]); end
    n_checks++; if (steer_a[0] !== 12'h333) begin n_errors++; $display("FAIL rr_steer got %h exp 333", steer_a[0]); end
    n_checks++; if (batt_a[0] !== 12'h444) begin n_errors++; $display("FAIL rr_batt got %h exp 444", batt_a[0]); end
    n_checks++; if (rr_a[0] !== 2'd0) begin n_errors++; $display("FAIL rr_wrap got %0d exp 0", rr_a[0]); end
  endtask

  task automatic test_busy_drop();
    int w0, c0;
    w0 = wrt0_tot; c0 = cmplt0_tot;
    nxt = 1'b1;
    step();
    nxt = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      nxt = (k % 2 == 0);
    end
    nxt = 1'b0;
    step(30);
    n_checks++; if (wrt0_tot - w0 != 2) begin n_errors++; $display("FAIL busy_wrt_count got %0d exp 2", wrt0_tot - w0); end
    n_checks++; if (cmplt0_tot - c0 != 1) begin n_errors++; $display("FAIL busy_cmplt_count got %0d exp 1", cmplt0_tot - c0); end
    n_checks++; if (rr_a[0] !== 2'd1) begin n_errors++; $display("FAIL busy_rr got %0d exp 1", rr_a[0]); end
    n_checks++; if (busy_a[0] !== 1'b0) begin n_errors++; $display("FAIL busy_idle got %b exp 0", busy_a[0]); end
    $display("busy_drop: wrts=%0d cmplts=%0d rr=%0d", wrt0_tot - w0, cmplt0_tot - c0, rr_a[0]);
  endtask

  task automatic test_gap();
    bit ok;
    do_reset();
    run_conv(ok);
    n_checks++; if (!ok) begin n_errors++; $display("FAIL gap_cmplt got timeout exp pulse"); end
    step(25);
    n_checks++; if (spacing[0] != 2) begin n_errors++; $display("FAIL gap1_spacing got %0d exp 2", spacing[0]); end
    n_checks++; if (spacing[1] != 1) begin n_errors++; $display("FAIL gap0_spacing got %0d exp 1", spacing[1]); end
    n_checks++; if (spacing[2] != 6) begin n_errors++; $display("FAIL gap5_spacing got %0d exp 6", spacing[2]); end
    n_checks++; if (lft_a[1] !== 12'h111 || lft_a[2] !== 12'h111)
      begin n_errors++; $display("FAIL gap_lft got %h %h exp 111 111", lft_a[1], lft_a[2]); end
    $display("gap: spacing g1=%0d g0=%0d g5=%0d", spacing[0], spacing[1], spacing[2]);
  endtask

  task automatic test_reset_abort();
    int w0, c0, q0;
    bit ok;
    do_reset();
    adc_val[0] = 12'hABC;
    nxt = 1'b1;
    step();
    nxt = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (done_a[0]) begin ok = 1'b1; break; end
      step();
    end
    n_checks++; if (!ok) begin n_errors++; $display("FAIL abort_gap_done got timeout exp done"); end
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    n_checks++; if ({busy_a[0], wrt_a[0], cmd_a[0], rr_a[0], lft_a[0]} !== 32'h0)
      begin n_errors++; $display("FAIL abort_gap_state got busy=%b wrt=%b cmd=%h rr=%0d lft=%h exp all 0", busy_a[0], wrt_a[0], cmd_a[0], rr_a[0], lft_a[0]); end

    w0 = wrt0_tot;
    nxt = 1'b1;
    step();
    nxt = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (wrt_a[0] && (wrt0_tot - w0 == 1)) begin ok = 1'b1; break; end
      step();
    end
    n_checks++; if (!ok) begin n_errors++; $display("FAIL abort_wait2_wrt got timeout exp second wrt"); end
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    c0 = cmplt0_tot;
    step(15);
    n_checks++; if (cmplt0_tot - c0 != 0) begin n_errors++; $display("FAIL abort_stale_cmplt got %0d exp 0", cmplt0_tot - c0); end
    n_checks++; if ({busy_a[0], rr_a[0], lft_a[0]} !== 15'h0)
      begin n_errors++; $display("FAIL abort_wait2_state got busy=%b rr=%0d lft=%h exp 0 0 000", busy_a[0], rr_a[0], lft_a[0]); end

    q0 = cmd_q.size();
    run_conv(ok);
    n_checks++; if (!ok) begin n_errors++; $display("FAIL abort_next_cmplt got timeout exp pulse"); end
    n_checks++; if (cmd_q[q0] !== 16'h0000) begin n_errors++; $display("FAIL abort_next_cmd got %h exp 0000", cmd_q[q0]); end
    n_checks++; if (lft_a[0] !== 12'hABC || rr_a[0] !== 2'd1)
      begin n_errors++; $display("FAIL abort_next_result got lft=%h rr=%0d exp ABC 1", lft_a[0], rr_a[0]); end
    $display("reset_abort: lft=%h rr=%0d", lft_a[0], rr_a[0]);
  endtask

  task automatic test_spurious_done();
    int c0;
    step(3);
    c0 = cmplt0_tot;
    tb_resp = 16'hFFFF;
    tb_done = 1'b1;
    step();
    tb_done = 1'b0;
    n_checks++; if ({cmplt_a[0], busy_a[0]} !== 2'b00)
      begin n_errors++; $display("FAIL spurious_flags got cmplt=%b busy=%b exp 0 0", cmplt_a[0], busy_a[0]); end
    step(3);
    n_checks++; if (cmplt0_tot - c0 != 0) begin n_errors++; $display("FAIL spurious_cmplt_count got %0d exp 0", cmplt0_tot - c0); end
    n_checks++; if ({lft_a[0], rght_a[0], steer_a[0], batt_a[0]} !== {12'hABC, 36'h0})
      begin n_errors++; $display("FAIL spurious_results got %h %h %h %h exp ABC 000 000 000", lft_a[0], rght_a[0], steer_a[0], batt_a[0]); end
    n_checks++; if (rr_a[0] !== 2'd1) begin n_errors++; $display("FAIL spurious_rr got %0d exp 1", rr_a[0]); end
    $display("spurious_done: lft=%h busy=%b rr=%0d", lft_a[0], busy_a[0], rr_a[0]);
  endtask

  initial begin
    rst_n   = 1'b0;
    nxt     = 1'b0;
    tb_done = 1'b0;
    tb_resp = 16'h0000;
    adc_val = '{12'h000, 12'h000, 12'h000, 12'h000};
    step(2);
    test_reset();
    test_single();
    test_round_robin();
    test_busy_drop();
    test_gap();
    test_reset_abort();
    test_spurious_done();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
